// File: rtl/clock_period_meter_pkg.sv
// rtl/clock_period_meter_pkg.sv - shared state encoding and default clock constants
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int CLK_HZ   = 25_000_000;
  localparam int CYC_1KHZ = 25_000;
  localparam int CYC_1HZ  = 25_000_000;

endpackage

// File: rtl/clock_period_meter_sync.sv
// rtl/clock_period_meter_sync.sv - 2-flop synchronizer plus edge register for async inputs
module sync_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures period/high time of a slow strobe in system clock cycles
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int CNT_W           = 25,
  parameter int EXPECTED_CYCLES = 25000,
  parameter int TOL_CYCLES      = 2,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic             clk_25MHz,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             meas_valid,
  output logic             in_range,
  output logic             timeout,
  output logic [7:0]       meas_count
);

  localparam logic [CNT_W-1:0] EXP_C    = CNT_W'(EXPECTED_CYCLES);
  localparam logic [CNT_W-1:0] TOL_C    = CNT_W'(TOL_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] period_next;
  logic             level;
  logic             rise;

  sync_rise_detect u_sync (
    .clk   (clk_25MHz),
    .rst   (rst),
    .din   (sig_in),
    .level (level),
    .rise  (rise)
  );

  // Subtract in whichever order avoids unsigned underflow.
  function automatic logic within_tol(input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] diff;
    diff = (p >= EXP_C) ? (p - EXP_C) : (EXP_C - p);
    return diff <= TOL_C;
  endfunction

  assign period_next = cnt + CNT_W'(1);

  always_ff @(posedge clk_25MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = ARM;
      ARM: begin
        if (!en)       state_next = IDLE;
        else if (rise) state_next = MEASURE;
      end
      MEASURE: begin
        if (!en)                          state_next = IDLE;
        else if (!rise && cnt == TMO_LAST) state_next = ARM;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      cnt           <= '0;
      hcnt          <= '0;
      period_cycles <= '0;
      high_cycles   <= '0;
      meas_valid    <= 1'b0;
      in_range      <= 1'b0;
      timeout       <= 1'b0;
      meas_count    <= '0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ARM: begin
          cnt  <= '0;
          hcnt <= (en && rise) ? CNT_W'(1) : '0;
        end
        MEASURE: begin
          // Disabling leaves results untouched; IDLE clears the counters next.
          if (en) begin
            if (rise) begin
              period_cycles <= period_next;
              high_cycles   <= hcnt;
              in_range      <= within_tol(period_next);
              meas_valid    <= 1'b1;
              meas_count    <= meas_count + 8'd1;
              timeout       <= 1'b0;
              cnt           <= '0;
              hcnt          <= CNT_W'(1);
            end else if (cnt == TMO_LAST) begin
              timeout  <= 1'b1;
              in_range <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (level) hcnt <= hcnt + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt  <= '0;
          hcnt <= '0;
        end
      endcase
    end
  end

endmodule
